// File: rtl/dct_pkg.sv
// dct_pkg: shared widths, fixed Q1.11 DCT coefficient table, sequencer state type
// and the round/saturate helpers used by the MAC.
package dct_pkg;
    localparam int N     = 8;
    localparam int DW    = 13;
    localparam int TW    = 16;
    localparam int CW    = 13;
    localparam int FRAC  = 11;
    localparam int ACC_W = 32;

    // C[u][k] = round(2048 * alpha(u) * cos((2k+1) * u * pi / 16))
    localparam int COEF [N][N] = '{
        '{ 724,   724,   724,   724,   724,   724,   724,   724},
        '{1004,   851,   569,   200,  -200,  -569,  -851, -1004},
        '{ 946,   392,  -392,  -946,  -946,  -392,   392,   946},
        '{ 851,  -200, -1004,  -569,   569,  1004,   200,  -851},
        '{ 724,  -724,  -724,   724,   724,  -724,  -724,   724},
        '{ 569, -1004,   200,   851,  -851,  -200,  1004,  -569},
        '{ 392,  -946,   946,  -392,  -392,   946,  -946,   392},
        '{ 200,  -569,   851, -1004,  1004,  -851,   569,  -200}
    };

    typedef enum logic [2:0] {IDLE, LOAD, PASS1, PASS2, DRAIN} dct_state_t;

    function automatic logic signed [ACC_W-1:0] rnd(input logic signed [ACC_W-1:0] v);
        return (v + ACC_W'(1 << (FRAC - 1))) >>> FRAC;
    endfunction

    function automatic logic signed [TW-1:0] sat(input logic signed [ACC_W-1:0] v, input logic to_dw);
        logic signed [ACC_W-1:0] hi;
        hi = to_dw ? ACC_W'((1 << (DW - 1)) - 1) : ACC_W'((1 << (TW - 1)) - 1);
        return v > hi ? TW'(hi) : v < -hi - 1 ? TW'(-hi - 1) : TW'(v);
    endfunction
endpackage

// File: rtl/dct_mac.sv
// dct_mac: shared signed multiply-accumulate; res_o taps the rounded, saturated
// value of the running sum including the current product.
module dct_mac
    import dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 last_i,
    input  logic                 sel_dw_i,
    input  logic signed [TW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic signed [TW-1:0] res_o
);
    logic signed [TW+CW-1:0] prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        prod  = (TW+CW)'(a_i) * (TW+CW)'(b_i);
        sum   = acc_q + ACC_W'(prod);
        acc_d = (clr_i || (en_i && last_i)) ? '0 : en_i ? sum : acc_q;
        res_o = sat(rnd(sum), sel_dw_i);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) acc_q <= '0;
        else acc_q <= acc_d;
endmodule

// File: rtl/dct_block_sequencer.sv
// dct_block_sequencer: loads one 8x8 block, steps a single MAC through the row
// pass (T = C*X) and column pass (Y = T*C^T), then streams Y out row-major.
module dct_block_sequencer
    import dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    input  logic                 abort
);
    dct_state_t state_q;
    logic [5:0] idx_q;
    logic [5:0] oidx_q;
    logic [8:0] cnt_q;
    logic signed [DW-1:0] x_mem [64];
    logic signed [TW-1:0] t_mem [64];
    logic signed [DW-1:0] y_mem [64];
    logic [2:0] ri, ci, ki;
    logic kill, p1, p2, mac_last;
    logic signed [TW-1:0] mac_a, mac_res;
    logic signed [CW-1:0] mac_b;

    always_comb begin
        {ri, ci, ki} = cnt_q;
        kill     = abort && state_q != IDLE;
        p1       = state_q == PASS1;
        p2       = state_q == PASS2;
        mac_last = ki == 3'd7;
        mac_a    = p1 ? TW'(x_mem[{ki, ci}]) : t_mem[{ri, ki}];
        mac_b    = CW'(p1 ? COEF[ri][ki] : COEF[ci][ki]);
    end

    dct_mac u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (p1 || p2),
        .clr_i    (kill),
        .last_i   (mac_last),
        .sel_dw_i (p2),
        .a_i      (mac_a),
        .b_i      (mac_b),
        .res_o    (mac_res)
    );

    // Block storage needs no reset: every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready && !abort) x_mem[idx_q] <= in_data;
        if (p1 && mac_last) t_mem[{ri, ci}] <= mac_res;
        if (p2 && mac_last) y_mem[{ri, ci}] <= DW'(mac_res);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            oidx_q    <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (kill) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            oidx_q    <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= LOAD;
                    in_ready <= 1'b1;
                end
                LOAD: if (in_valid) begin
                    idx_q <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_q  <= PASS1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                PASS1: begin
                    cnt_q <= cnt_q + 9'd1;
                    if (&cnt_q) state_q <= PASS2;
                end
                PASS2: begin
                    cnt_q <= cnt_q + 9'd1;
                    if (&cnt_q) begin
                        state_q   <= DRAIN;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= y_mem[0];
                        out_last  <= 1'b0;
                        oidx_q    <= '0;
                    end
                end
                DRAIN: if (out_ready) begin
                    oidx_q   <= oidx_q + 6'd1;
                    out_data <= y_mem[oidx_q + 6'd1];
                    out_last <= oidx_q == 6'd62;
                    if (oidx_q == 6'd63) begin
                        state_q   <= LOAD;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dct_block_sequencer.sv
// tb_dct_block_sequencer: randomized block traffic against a matrix-level DCT
// reference, with abort, backpressure and mid-pass reset scenarios.
module tb_dct_block_sequencer;
    localparam real PI = 3.141592653589793;

    logic clk = 1'b0;
    logic reset_n;
    logic in_valid;
    logic in_ready;
    logic signed [12:0] in_data;
    logic out_valid;
    logic out_ready;
    logic signed [12:0] out_data;
    logic out_last;
    logic busy;
    logic abort;

    int checks = 0;
    int errors = 0;
    int c [8][8];
    int xs [64];
    int ys [64];
    int gy [64];

    dct_block_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(input int v);
        return (v + 1024) >>> 11;
    endfunction

    function automatic int clamp(input int v, input int lim);
        return v > lim ? lim : v < -lim - 1 ? -lim - 1 : v;
    endfunction

    // Y = sat13(round(T * C^T)) with T = sat16(round(C * X))
    function automatic void model();
        int t [8][8];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                int s = 0;
                for (int k = 0; k < 8; k++) s += c[i][k] * xs[k*8+j];
                t[i][j] = clamp(rnd(s), 32767);
            end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                int s = 0;
                for (int k = 0; k < 8; k++) s += t[i][k] * c[j][k];
                ys[i*8+j] = clamp(rnd(s), 4095);
            end
    endfunction

    function automatic void fill_const(input int v);
        for (int i = 0; i < 64; i++) xs[i] = v;
        model();
    endfunction

    function automatic void fill_rand();
        int lims [4] = '{15, 255, 1000, 4095};
        int lim = lims[$urandom_range(0, 3)];
        for (int i = 0; i < 64; i++) xs[i] = int'($urandom_range(0, 2 * lim)) - lim;
        model();
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic load_block(input int n);
        int idx = 0;
        int to = 0;
        while (idx < n && to < 5000) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = 13'(xs[idx]);
            if (in_valid && in_ready) idx++;
            to++;
        end
        if (to >= 5000) chk("load_timeout", idx, n);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        int b = int'(busy);
        while (!out_valid && n < 3000) begin
            @(negedge clk);
            n++;
            b += int'(busy);
            in_valid = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
        end
        chk("latency_edges", n, 1024);
        chk("busy_cycles", b, 1024);
    endtask

    task automatic drain(input int mode, input int stop);
        int oi = 0;
        int to = 0;
        int ph = 0;
        logic hs;
        while (oi < stop && to < 3000) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, ys[oi]);
            chk("out_last", out_last, int'(oi == 63));
            gy[oi] = out_data;
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (ph % 4 == 0) : ($urandom_range(0, 1) == 1);
            in_valid = ($urandom_range(0, 1) == 1);
            ph++;
            hs = out_ready;
            @(negedge clk);
            if (hs) oi++;
            to++;
        end
        if (to >= 3000) chk("drain_timeout", oi, stop);
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (stop == 64) begin
            chk("in_ready_after_last", in_ready, 1);
            chk("out_valid_after_last", out_valid, 0);
        end
    endtask

    task automatic run(input int mode);
        load_block(64);
        wait_out();
        drain(mode, 64);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        abort = 1'b0;
        for (int u = 0; u < 8; u++)
            for (int k = 0; k < 8; k++) begin
                real r;
                r = 2048.0 * (u == 0 ? $sqrt(0.125) : 0.5) * $cos((2 * k + 1) * u * PI / 16.0);
                c[u][k] = r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
            end
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_rise", in_ready, 1);

        fill_const(100);
        run(0);
        chk("dc100_y00", gy[0], 800);
        fill_const(4095);
        run(2);
        chk("sat_y00", gy[0], 4095);
        fill_const(0);
        xs[0] = 1000;
        model();
        run(0);
        chk("impulse_y00", gy[0], 125);
        fill_rand();
        run(1);

        fill_rand();
        load_block(30);
        do_abort();
        fill_const(100);
        run(0);
        chk("abort_load_y00", gy[0], 800);

        fill_rand();
        load_block(64);
        repeat (700) @(negedge clk);
        do_abort();
        fill_const(100);
        run(0);
        chk("abort_pass2_y00", gy[0], 800);

        fill_rand();
        load_block(64);
        wait_out();
        drain(0, 10);
        do_abort();
        fill_const(100);
        run(0);
        chk("abort_drain_y00", gy[0], 800);

        fill_rand();
        load_block(64);
        repeat (200) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_release_in_ready", in_ready, 0);
        @(negedge clk);
        chk("rst_in_ready_rise", in_ready, 1);
        fill_rand();
        run(2);

        repeat (4) begin
            fill_rand();
            run(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
